// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: op codes, FSM states
// and default geometry of the unified instruction/data memory.
package mem_access_ctrl_pkg;

  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CNT_W  = 11;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_CLR  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_ctrl_fetch.sv
// Instruction fetch path: registers the PC onto the memory fetch port and
// captures Instruction one cycle later with a single-cycle valid pulse.
module mem_fetch_stage #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       Instruction,
  output logic [31:0]       Read_PC,
  output logic [31:0]       instr_out,
  output logic              instr_valid
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  logic [31:0]       r_instr;
  logic              r_valid;

  // r_pend marks that Read_PC carries a fresh fetch address this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= '0;
      r_pend  <= 1'b0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pend  <= fetch_en;
      r_valid <= r_pend;
      if (fetch_en) r_pc <= pc_in;
      if (r_pend) r_instr <= Instruction;
    end
  end

  assign Read_PC     = {{(32-ADDR_W){1'b0}}, r_pc};
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-port sequencer for load/store/clear requests with a registered response,
// plus the independent instruction fetch stage.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [CNT_W-1:0]  req_count,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [31:0]       Read_PC,
  output logic [31:0]       R_W_Addr,
  output logic [31:0]       DataWrite,
  output logic              Op2En,
  output logic              Op2RW,
  output logic              M_Clear,
  input  logic [31:0]       DataRead,
  input  logic [31:0]       Instruction
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; a response transfers where resp_valid and
  // resp_ready are both 1. resp_valid and its payload hold until then.
  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_wdata;
  logic              r_op2en;
  logic              r_op2rw;
  logic              r_mclear;
  logic              r_ready;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_rdata;
  logic              w_accept;

  assign w_accept = r_ready && req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_op2en      <= 1'b0;
      r_op2rw      <= 1'b0;
      r_mclear     <= 1'b0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_addr     <= req_addr;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
            case (op_e'(req_op))
              OP_LOAD: begin
                r_op2en <= 1'b1;
                r_op2rw <= 1'b0;
                r_state <= ST_RD;
              end
              OP_STORE: begin
                r_op2en <= 1'b1;
                r_op2rw <= 1'b1;
                r_wdata <= req_wdata;
                r_state <= ST_WR;
              end
              OP_CLEAR: begin
                if (req_count == '0) begin
                  r_resp_valid <= 1'b1;
                  r_state      <= ST_RESP;
                end else begin
                  r_mclear <= 1'b1;
                  r_cnt    <= req_count;
                  r_state  <= ST_CLR;
                end
              end
              default: begin
                r_resp_err   <= 1'b1;
                r_resp_valid <= 1'b1;
                r_state      <= ST_RESP;
              end
            endcase
          end
        end
        ST_RD: begin
          r_rdata      <= DataRead;
          r_op2en      <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_WR: begin
          r_op2en      <= 1'b0;
          r_op2rw      <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_CLR: begin
          // The word at r_addr is cleared on this edge; decide whether it was the last.
          if (r_cnt == CNT_W'(1)) begin
            r_mclear     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_addr == LAST_ADDR) begin
            r_mclear     <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
            r_ready      <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_resp_err;
  assign R_W_Addr   = {{(32-ADDR_W){1'b0}}, r_addr};
  assign DataWrite  = r_wdata;
  assign Op2En      = r_op2en;
  assign Op2RW      = r_op2rw;
  assign M_Clear    = r_mclear;

  mem_fetch_stage #(.ADDR_W(ADDR_W)) u_fetch (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .pc_in       (pc_in),
    .Instruction (Instruction),
    .Read_PC     (Read_PC),
    .instr_out   (instr_out),
    .instr_valid (instr_valid)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl driving a behavioural 1024-word memory.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [10:0] req_count;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        fetch_en;
  logic [9:0]  pc_in;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] Read_PC;
  logic [31:0] R_W_Addr;
  logic [31:0] DataWrite;
  logic        Op2En;
  logic        Op2RW;
  logic        M_Clear;
  logic [31:0] DataRead;
  logic [31:0] Instruction;

  logic [31:0] mem [0:1023];
  logic        tb_init;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_count(req_count),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .fetch_en(fetch_en), .pc_in(pc_in),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .Read_PC(Read_PC), .R_W_Addr(R_W_Addr), .DataWrite(DataWrite),
    .Op2En(Op2En), .Op2RW(Op2RW), .M_Clear(M_Clear),
    .DataRead(DataRead), .Instruction(Instruction)
  );

  // Memory: initial pattern A000_0000|index, clear takes priority over write.
  always_ff @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    end else if (M_Clear) begin
      mem[R_W_Addr[9:0]] <= 32'h0;
    end else if (Op2En && Op2RW) begin
      mem[R_W_Addr[9:0]] <= DataWrite;
    end
  end

  assign DataRead    = mem[R_W_Addr[9:0]];
  assign Instruction = mem[Read_PC[9:0]];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [10:0] cnt);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_count = cnt;
    tick;
    acc_cyc   = cyc - 1;
    req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_resp(input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int guard;
    guard = 0;
    while (!resp_valid && guard < 200) begin
      tick;
      guard++;
    end
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("mem_ctrl_idle_in_resp", 32'({Op2En, M_Clear}), 32'd0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("resp_consumed", 32'(resp_valid), 32'd0);
    chk("req_ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  task automatic load_check(input logic [9:0] addr, input logic [31:0] exp);
    issue(2'(OP_LOAD), addr, 32'h0, 11'd0);
    chk("rd_op2en", 32'(Op2En), 32'd1);
    chk("rd_op2rw", 32'(Op2RW), 32'd0);
    chk("rd_addr", R_W_Addr, 32'(addr));
    wait_resp(2, exp, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tb_init = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0; req_count = '0;
    resp_ready = 1'b0; fetch_en = 1'b0; pc_in = '0;
    tick; tick;
    tb_init = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_ctrl", 32'({Op2En, Op2RW, M_Clear}), 32'd0);
    chk("rst_rw_addr", R_W_Addr, 32'd0);
    chk("rst_read_pc", Read_PC, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    tick;
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Store then load back.
    issue(2'(OP_STORE), 10'd5, 32'hDEADBEEF, 11'd0);
    chk("wr_op2en", 32'(Op2En), 32'd1);
    chk("wr_op2rw", 32'(Op2RW), 32'd1);
    chk("wr_data", DataWrite, 32'hDEADBEEF);
    chk("wr_addr", R_W_Addr, 32'd5);
    wait_resp(2, 32'h0, 1'b0);
    load_check(10'd5, 32'hDEADBEEF);

    // Clear inside a stored block.
    for (int i = 8; i <= 12; i++) begin
      issue(2'(OP_STORE), 10'(i), 32'h1111_0000 + 32'(i), 11'd0);
      wait_resp(2, 32'h0, 1'b0);
    end
    issue(2'(OP_CLEAR), 10'd8, 32'h0, 11'd4);
    chk("clr_mclear", 32'(M_Clear), 32'd1);
    chk("clr_op2en", 32'(Op2En), 32'd0);
    wait_resp(5, 32'h0, 1'b0);
    for (int i = 8; i <= 11; i++) load_check(10'(i), 32'h0);
    load_check(10'd12, 32'h1111_000C);

    // Clear truncated at the top of memory.
    issue(2'(OP_CLEAR), 10'd1020, 32'h0, 11'd10);
    wait_resp(5, 32'h0, 1'b1);
    for (int i = 1020; i <= 1023; i++) load_check(10'(i), 32'h0);
    load_check(10'd0, 32'hA000_0000);
    load_check(10'd1019, 32'hA000_03FB);

    // Zero-count clear and reserved op answer immediately.
    issue(2'(OP_CLEAR), 10'd30, 32'h0, 11'd0);
    wait_resp(1, 32'h0, 1'b0);
    load_check(10'd30, 32'hA000_001E);
    issue(2'(OP_RSVD), 10'd31, 32'h0, 11'd0);
    wait_resp(1, 32'h0, 1'b1);

    // Response held under backpressure.
    issue(2'(OP_LOAD), 10'd12, 32'h0, 11'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, 32'h1111_000C);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      if (k < 3) tick;
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("hold_consumed", 32'(resp_valid), 32'd0);
    chk("hold_req_ready_after", 32'(req_ready), 32'd1);

    // Pipelined fetches while the data port is clearing.
    issue(2'(OP_CLEAR), 10'd100, 32'h0, 11'd6);
    fetch_en = 1'b1; pc_in = 10'd0;
    tick;
    chk("fetch_pc0", Read_PC, 32'd0);
    chk("fetch_valid_t1", 32'(instr_valid), 32'd0);
    pc_in = 10'd1;
    tick;
    chk("fetch_pc1", Read_PC, 32'd1);
    chk("fetch_valid_t2", 32'(instr_valid), 32'd1);
    chk("fetch_instr0", instr_out, 32'hA000_0000);
    pc_in = 10'd2;
    tick;
    fetch_en = 1'b0;
    chk("fetch_pc2", Read_PC, 32'd2);
    chk("fetch_valid_t3", 32'(instr_valid), 32'd1);
    chk("fetch_instr1", instr_out, 32'hA000_0001);
    tick;
    chk("fetch_valid_t4", 32'(instr_valid), 32'd1);
    chk("fetch_instr2", instr_out, 32'hA000_0002);
    tick;
    chk("fetch_valid_t5", 32'(instr_valid), 32'd0);
    wait_resp(7, 32'h0, 1'b0);
    load_check(10'd105, 32'h0);
    load_check(10'd106, 32'hA000_006A);

    // Reset in the middle of a clear, after three words.
    issue(2'(OP_CLEAR), 10'd200, 32'h0, 11'd6);
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_mem_ctrl", 32'({Op2En, Op2RW, M_Clear}), 32'd0);
    chk("midrst_rw_addr", R_W_Addr, 32'd0);
    reset = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
      tick;
    end
    for (int i = 200; i <= 202; i++) load_check(10'(i), 32'h0);
    for (int i = 203; i <= 205; i++) load_check(10'(i), 32'hA000_0000 | 32'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
